// File: rtl/gray_decoder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module     : gray_decoder                                                   |
// | Description: Receive-side gray-to-binary decoder with a 2-stage pipeline.   |
// |              Checks that successive samples step by 0 or +1 (mod 2^WIDTH).  |
// |              Reports each violation as a per-sample pulse, as a sticky flag |
// |              and as a saturating error count.                               |
// |              Optional macro GRAY_DEC_SYNC_EN adds a two-flop synchroniser   |
// |              ahead of the first stage, which raises the latency to 4.       |
// | Revision   : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module gray_decoder #(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 in_valid,
  input  logic                 clr_err,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 out_valid,
  output logic                 step_err,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [WIDTH-1:0]     C_STEP_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ERR_CNT_W-1:0] C_CNT_ONE  = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_CNT_W-1:0] C_CNT_MAX  = {ERR_CNT_W{1'b1}};

  typedef enum logic [0:0] {
    ACQUIRE = 1'b0,
    TRACK   = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_s_gray;
  logic             w_s_valid;
  logic [WIDTH-1:0] r_g1;
  logic             r_v1;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] w_bin;
  logic [WIDTH-1:0] w_delta;
  logic             w_step;

`ifdef GRAY_DEC_SYNC_EN
  logic [WIDTH-1:0] r_sync_g0;
  logic [WIDTH-1:0] r_sync_g1;
  logic             r_sync_v0;
  logic             r_sync_v1;

  // Two-flop synchroniser on the incoming sample and its valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync_g0 <= '0;
      r_sync_g1 <= '0;
      r_sync_v0 <= 1'b0;
      r_sync_v1 <= 1'b0;
    end else begin
      r_sync_g0 <= gray_in;
      r_sync_g1 <= r_sync_g0;
      r_sync_v0 <= in_valid;
      r_sync_v1 <= r_sync_v0;
    end
  end

  assign w_s_gray  = r_sync_g1;
  assign w_s_valid = r_sync_v1;
`else
  assign w_s_gray  = gray_in;
  assign w_s_valid = in_valid;
`endif

  // Stage 1: capture the gray sample when it is valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_g1 <= '0;
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= w_s_valid;
      if (w_s_valid) begin
        r_g1 <= w_s_gray;
      end
    end
  end

  // Gray to binary: each binary bit is the XOR of all gray bits at or above it
  always_comb begin
    w_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_bin[i] = ^(r_g1 >> i);
    end
  end

  // Next state and step check; the first sample after reset only sets the reference
  always_comb begin
    w_state_nxt = r_state;
    w_step      = 1'b0;
    w_delta     = w_bin - r_prev;
    case (r_state)
      ACQUIRE: begin
        if (r_v1) begin
          w_state_nxt = TRACK;
        end
      end
      TRACK: begin
        if (r_v1 && (w_delta > C_STEP_ONE)) begin
          w_step = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ACQUIRE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ACQUIRE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Stage 2: decoded output, reference value and per-sample error pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_out   <= '0;
      out_valid <= 1'b0;
      step_err  <= 1'b0;
      r_prev    <= '0;
    end else begin
      out_valid <= r_v1;
      step_err  <= w_step;
      if (r_v1) begin
        bin_out <= w_bin;
        r_prev  <= w_bin;
      end
    end
  end

  // Sticky flag and saturating counter; a new error overrides a clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else if (w_step) begin
      err_sticky <= 1'b1;
      if (clr_err) begin
        err_cnt <= C_CNT_ONE;
      end else if (err_cnt != C_CNT_MAX) begin
        err_cnt <= err_cnt + C_CNT_ONE;
      end
    end else if (clr_err) begin
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end
  end

endmodule
`default_nettype wire
